i2c_cond_gen: RTL and testbench

Parametrised successor to the single-shot start/stop generator. Runs on the system clock and produces I2C START, REPEATED START and STOP conditions with programmable quarter-bit timing, driving open-drain enables. Commands arrive on a valid/ready handshake; completion and errors are reported as one-cycle pulses. Tracks bus ownership so illegal sequences are rejected. Sits between the I2C byte engine and the pad open-drain buffers.

---
 rtl/i2c_cond_gen_pkg.sv | 57 +++++
 rtl/i2c_cond_gen_if.sv | 25 ++
 rtl/i2c_cond_gen_qtr_timer.sv | 30 +++
 rtl/i2c_cond_gen.sv | 126 ++++++++++++
 tb/tb_i2c_cond_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_cond_gen_pkg.sv
// Shared encodings for the I2C START/STOP/RESTART condition generator:
// command codes, FSM phases and the per-phase open-drain line levels.
package i2c_cond_pkg;

  typedef enum logic [1:0] {
    CMD_START   = 2'b00,
    CMD_STOP    = 2'b01,
    CMD_RESTART = 2'b10,
    CMD_RSVD    = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    RS_PREP,
    ST_SETUP,
    ST_HOLD,
    ST_LOW,
    SP_PREP,
    SP_SETUP,
    SP_HOLD
  } state_e;

  // {scl_oe, sda_oe} driven while in a phase; IDLE keeps whatever was last driven
  function automatic logic [1:0] phase_lines(state_e s);
    logic [1:0] lines;
    lines = 2'b00;
    case (s)
      RS_PREP:  lines = 2'b10;
      ST_SETUP: lines = 2'b00;
      ST_HOLD:  lines = 2'b01;
      ST_LOW:   lines = 2'b11;
      SP_PREP:  lines = 2'b11;
      SP_SETUP: lines = 2'b01;
      SP_HOLD:  lines = 2'b00;
      default:  lines = 2'b00;
    endcase
    return lines;
  endfunction

  // Phases where SCL is released and a slave may hold it low
  function automatic logic is_stretch_phase(state_e s);
    return (s == ST_SETUP) || (s == ST_HOLD) || (s == SP_SETUP) || (s == SP_HOLD);
  endfunction

  function automatic logic cmd_legal(cmd_e c, logic owned);
    logic ok;
    ok = 1'b0;
    case (c)
      CMD_START:   ok = !owned;
      CMD_STOP:    ok = owned;
      CMD_RESTART: ok = owned;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/i2c_cond_gen_if.sv
// Command handshake, status pulses and pad-side lines of the condition generator.
// master = byte engine / pad side, slave = the generator itself.
interface i2c_cond_gen_if;

  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       done;
  logic       err;
  logic       owned;
  logic       scl_in;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    output cmd_valid, cmd, scl_in,
    input  cmd_ready, done, err, owned, scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd, scl_in,
    output cmd_ready, done, err, owned, scl_oe, sda_oe
  );

endinterface

// File: rtl/i2c_cond_gen_qtr_timer.sv
// Quarter-bit phase timer: loads QTR_CYCLES-1 on phase entry, counts down while
// run is high and flags expiry combinationally at zero.
module i2c_qtr_timer #(
  parameter int QTR_CYCLES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(QTR_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(QTR_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/i2c_cond_gen.sv
// I2C START / REPEATED START / STOP generator with quarter-bit phase timing and
// bus-ownership tracking. Optional macro CLK_STRETCH_EN enables clock stretching.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | ready for a command, lines hold last levels
//   RS_PREP  | restart: SCL low, SDA released
//   ST_SETUP | both released (start setup)
//   ST_HOLD  | SDA low with SCL high: the START edge
//   ST_LOW   | both low, bus now owned
//   SP_PREP  | stop: both low
//   SP_SETUP | SCL released, SDA low
//   SP_HOLD  | SDA released with SCL high: the STOP edge
module i2c_cond_gen
  import i2c_cond_pkg::*;
#(
  parameter int QTR_CYCLES = 250
) (
  input  logic           clk,
  input  logic           rst,
  i2c_cond_gen_if.slave  bus
);

  state_e state;
  state_e nxt;
  logic   scl_q;
  logic   sda_q;
  logic   done_q;
  logic   err_q;
  logic   owned_q;

  logic   accept;
  logic   legal;
  logic   load;
  logic   run;
  logic   expire;
  logic   finishing;

  always_comb begin
    accept = bus.cmd_valid && (state == IDLE);
    legal  = cmd_legal(cmd_e'(bus.cmd), owned_q);
    nxt    = state;
    case (state)
      IDLE: begin
        if (accept && legal) begin
          case (cmd_e'(bus.cmd))
            CMD_START:   nxt = ST_SETUP;
            CMD_RESTART: nxt = RS_PREP;
            default:     nxt = SP_PREP;
          endcase
        end
      end
      RS_PREP:  if (expire) nxt = ST_SETUP;
      ST_SETUP: if (expire) nxt = ST_HOLD;
      ST_HOLD:  if (expire) nxt = ST_LOW;
      ST_LOW:   if (expire) nxt = IDLE;
      SP_PREP:  if (expire) nxt = SP_SETUP;
      SP_SETUP: if (expire) nxt = SP_HOLD;
      SP_HOLD:  if (expire) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // every transition lands in a different state, so a change into a non-IDLE state is a phase entry
    load      = (nxt != state) && (nxt != IDLE);
    finishing = (state != IDLE) && (nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      owned_q <= 1'b0;
    end else begin
      state  <= nxt;
      done_q <= finishing;
      err_q  <= accept && !legal;
      if (load) begin
        {scl_q, sda_q} <= phase_lines(nxt);
      end
      if (finishing) begin
        owned_q <= (state == ST_LOW);
      end
    end
  end

`ifdef CLK_STRETCH_EN
  // Once SCL is seen high in a phase the count proceeds even if a slave pulls it low again
  logic scl_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_seen <= 1'b0;
    end else if (load) begin
      scl_seen <= 1'b0;
    end else if (bus.scl_in) begin
      scl_seen <= 1'b1;
    end
  end

  assign run = (state != IDLE) && (!is_stretch_phase(state) || bus.scl_in || scl_seen);
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign run = (state != IDLE);
`endif

  i2c_qtr_timer #(
    .QTR_CYCLES(QTR_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .run    (run),
    .expire (expire)
  );

  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.owned     = owned_q;
  assign bus.scl_oe    = scl_q;
  assign bus.sda_oe    = sda_q;

endmodule

// File: tb/tb_i2c_cond_gen.sv
// Scoreboard bench for i2c_cond_gen with QTR_CYCLES=4: stimulus queues expected
// pulses and line snapshots, a negedge monitor compares them against the DUT.
module tb_i2c_cond_gen;

  localparam int Q = 4;

  logic clk;
  logic rst;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 0;

  i2c_cond_gen_if bus ();

  i2c_cond_gen #(.QTR_CYCLES(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {bit is_err; int at; bit owned;} ev_t;
  typedef struct {int at; bit scl; bit sda; bit owned; bit ready;} pr_t;

  ev_t ev_q[$];
  pr_t pr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0d: got %0d expected %0d", name, edge_cnt, act, exp);
  endtask

  task automatic expect_ev(input bit is_err, input int at, input bit owned);
    ev_t e;
    e.is_err = is_err;
    e.at     = at;
    e.owned  = owned;
    ev_q.push_back(e);
  endtask

  task automatic probe(input int at, input bit scl, input bit sda, input bit owned, input bit ready);
    pr_t p;
    p.at    = at;
    p.scl   = scl;
    p.sda   = sda;
    p.owned = owned;
    p.ready = ready;
    pr_q.push_back(p);
  endtask

  // acc = edge count right after the accepting edge; cycle n of the command is acc+n-1
  task automatic issue(input logic [1:0] c, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_wait: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, waited);
      acc = edge_cnt;
      return;
    end
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc = edge_cnt;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.done === 1'b1 || bus.err === 1'b1) begin
        if (ev_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse @%0d: done=%b err=%b, required no pulse", edge_cnt, bus.done, bus.err);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          check("pulse_kind_err", int'(bus.err), int'(e.is_err));
          check("pulse_kind_done", int'(bus.done), int'(!e.is_err));
          check("pulse_time", edge_cnt, e.at);
          check("pulse_owned", int'(bus.owned), int'(e.owned));
        end
      end else if (ev_q.size() > 0 && ev_q[0].at <= edge_cnt) begin
        ev_t e;
        e = ev_q.pop_front();
        check("pulse_missing", edge_cnt + 1, e.at);
      end
      while (pr_q.size() > 0 && pr_q[0].at <= edge_cnt) begin
        pr_t p;
        p = pr_q.pop_front();
        check("probe_time", edge_cnt, p.at);
        check("scl_oe", int'(bus.scl_oe), int'(p.scl));
        check("sda_oe", int'(bus.sda_oe), int'(p.sda));
        check("owned", int'(bus.owned), int'(p.owned));
        check("cmd_ready", int'(bus.cmd_ready), int'(p.ready));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int a;
    int a2;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    bus.scl_in    = 1'b1;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    probe(edge_cnt, 0, 0, 0, 1);
    mon_en = 1;

    // 2: START from idle
    issue(2'b00, a);
    probe(a + 3, 0, 0, 0, 0);
    probe(a + 4, 0, 1, 0, 0);
    probe(a + 7, 0, 1, 0, 0);
    probe(a + 8, 1, 1, 0, 0);
    probe(a + 11, 1, 1, 0, 0);
    probe(a + 12, 1, 1, 1, 1);
    expect_ev(0, a + 12, 1);

    // 3: RESTART then back-to-back STOP
    issue(2'b10, a);
    probe(a + 0, 1, 0, 1, 0);
    probe(a + 3, 1, 0, 1, 0);
    probe(a + 4, 0, 0, 1, 0);
    probe(a + 7, 0, 0, 1, 0);
    probe(a + 8, 0, 1, 1, 0);
    probe(a + 12, 1, 1, 1, 0);
    probe(a + 15, 1, 1, 1, 0);
    probe(a + 16, 1, 1, 1, 1);
    expect_ev(0, a + 16, 1);
    issue(2'b01, a2);
    check("b2b_accept", a2, a + 17);
    probe(a2 + 0, 1, 1, 1, 0);
    probe(a2 + 4, 0, 1, 1, 0);
    probe(a2 + 8, 0, 0, 1, 0);
    probe(a2 + 11, 0, 0, 1, 0);
    probe(a2 + 12, 0, 0, 0, 1);
    expect_ev(0, a2 + 12, 0);

    // 4: illegal commands
    issue(2'b01, a);
    expect_ev(1, a, 0);
    probe(a, 0, 0, 0, 1);
    issue(2'b11, a);
    expect_ev(1, a, 0);
    probe(a, 0, 0, 0, 1);
    issue(2'b10, a);
    expect_ev(1, a, 0);
    issue(2'b00, a);
    expect_ev(0, a + 12, 1);
    issue(2'b00, a);
    expect_ev(1, a, 1);
    probe(a, 1, 1, 1, 1);
    issue(2'b11, a);
    expect_ev(1, a, 1);
    probe(a, 1, 1, 1, 1);

    // 5: reset mid-START
    issue(2'b01, a);
    expect_ev(0, a + 12, 0);
    issue(2'b00, a);
    probe(a + 5, 0, 1, 0, 0);
    probe(a + 6, 0, 0, 0, 1);
    do @(negedge clk); while (edge_cnt < a + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(2'b00, a);
    expect_ev(0, a + 12, 1);
    probe(a + 12, 1, 1, 1, 1);

`ifdef CLK_STRETCH_EN
    // 6: RESTART with SCL held low by a slave
    issue(2'b10, a);
    probe(a + 17, 0, 0, 1, 0);
    probe(a + 18, 0, 1, 1, 0);
    probe(a + 22, 1, 1, 1, 0);
    probe(a + 26, 1, 1, 1, 1);
    expect_ev(0, a + 26, 1);
    do @(negedge clk); while (edge_cnt < a + 4);
    bus.scl_in = 1'b0;
    do @(negedge clk); while (edge_cnt < a + 14);
    bus.scl_in = 1'b1;
`endif

    repeat (40) @(negedge clk);
    check("events_left", ev_q.size(), 0);
    check("probes_left", pr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
